strait_pe_selftest: RTL and testbench

//  Next-generation systolic PE for the STRAIT array: weight-stationary MAC with double-buffered weights
//  (shadow chain + active reg, swap on command), runtime signed/unsigned mode, scan/disable bypass, and a

---
 rtl/strait_pkg.sv | 10 +
 rtl/strait_mac.sv | 19 +
 rtl/strait_pe_selftest.sv | 104 ++++++++++
 tb/tb_strait_pe_selftest.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/strait_pkg.sv
// strait_pkg: shared constants, FSM states and width helper for the STRAIT PE
package strait_pkg;
   localparam int LFSR_WIDTH = 32;
   localparam logic [LFSR_WIDTH-1:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 32'hACE1_1D5B;
   typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;
   function automatic int psum_width(input int w, input int a, input int n);
      return w + a + $clog2(n);
   endfunction
endpackage

// File: rtl/strait_mac.sv
// strait_mac: signed/unsigned multiply-add wrapping modulo 2^P
module strait_mac #(
   parameter int W = 8,
   parameter int A = 8,
   parameter int P = 19
) (
   input  logic [W-1:0] weight,
   input  logic [A-1:0] activation,
   input  logic [P-1:0] psum,
   input  logic         is_signed,
   output logic [P-1:0] mac
);
   logic [P-1:0] wx, ax;
   always_comb begin
      wx  = {{(P-W){is_signed & weight[W-1]}}, weight};
      ax  = {{(P-A){is_signed & activation[A-1]}}, activation};
      mac = wx * ax + psum;
   end
endmodule

// File: rtl/strait_pe_selftest.sv
// strait_pe_selftest: weight-stationary systolic PE with double-buffered weights and LFSR/MISR self-test
module strait_pe_selftest import strait_pkg::*; #(
   parameter int SYSTOLIC_SIZE = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACTIVATION_WIDTH = 8,
   parameter int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE),
   parameter int TEST_CYCLES = 64,
   parameter logic [31:0] LFSR_SEED = DEFAULT_SEED
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WEIGHT_WIDTH-1:0]      weight_in,
   input  logic                         weight_load,
   input  logic                         weight_swap,
   input  logic [ACTIVATION_WIDTH-1:0]  activation,
   input  logic [PARTIAL_SUM_WIDTH-1:0] partial_sum_in,
   input  logic                         is_signed,
   input  logic                         scan_en,
   input  logic                         pe_disable_in,
   input  logic                         test_start,
   input  logic [PARTIAL_SUM_WIDTH-1:0] golden_sig,
   output logic [WEIGHT_WIDTH-1:0]      weight_out,
   output logic [ACTIVATION_WIDTH-1:0]  activation_out,
   output logic [PARTIAL_SUM_WIDTH-1:0] partial_sum_out,
   output logic                         pe_disable_out,
   output logic                         test_busy,
   output logic                         test_done,
   output logic                         test_fail
);
   localparam int W = WEIGHT_WIDTH;
   localparam int A = ACTIVATION_WIDTH;
   localparam int P = PARTIAL_SUM_WIDTH;
   localparam int CW = $clog2(TEST_CYCLES + 1);
   logic [W-1:0] active;
   logic [P-1:0] mac, tmac, misr;
   logic [LFSR_WIDTH-1:0] lfsr;
   logic [CW-1:0] cnt;
   logic fault;
   state_t state;
   strait_mac #(.W(W), .A(A), .P(P)) u_dp (
      .weight(active), .activation(activation_out), .psum(partial_sum_in),
      .is_signed(is_signed), .mac(mac)
   );
   strait_mac #(.W(W), .A(A), .P(P)) u_st (
      .weight(lfsr[W-1:0]), .activation(lfsr[LFSR_WIDTH-1 -: A]), .psum({P{1'b0}}),
      .is_signed(is_signed), .mac(tmac)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         weight_out      <= '0;
         active          <= '0;
         activation_out  <= '0;
         partial_sum_out <= '0;
         pe_disable_out  <= 1'b0;
      end else begin
         if (weight_load) weight_out <= weight_in;
         if (weight_swap) active <= weight_out;
         activation_out  <= activation;
         partial_sum_out <= (scan_en | pe_disable_in | fault | test_busy) ? partial_sum_in : mac;
         pe_disable_out  <= pe_disable_in | fault;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         lfsr      <= LFSR_SEED;
         misr      <= '0;
         fault     <= 1'b0;
         test_fail <= 1'b0;
         test_busy <= 1'b0;
         test_done <= 1'b0;
      end else begin
         case (state)
            IDLE: if (test_start) begin
               state     <= RUN;
               cnt       <= '0;
               lfsr      <= LFSR_SEED;
               misr      <= '0;
               fault     <= 1'b0;
               test_fail <= 1'b0;
               test_busy <= 1'b1;
            end
            RUN: begin
               lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & LFSR_POLY)};
               misr <= {misr[P-2:0], misr[P-1]} ^ tmac;
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(TEST_CYCLES - 1)) begin
                  state     <= CHECK;
                  test_done <= 1'b1;
               end
            end
            CHECK: begin
               state     <= IDLE;
               fault     <= misr != golden_sig;
               test_fail <= misr != golden_sig;
               test_done <= 1'b0;
               test_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_strait_pe_selftest.sv
// tb_strait_pe_selftest: directed scoreboard bench for the STRAIT PE datapath and self-test
module tb_strait_pe_selftest;
   localparam int W = 8, A = 8, P = 19, TC = 64;
   localparam logic [31:0] SEED = 32'hACE1_1D5B;
   logic clk = 1'b0, rst = 1'b1;
   logic [W-1:0] weight_in = '0, weight_out;
   logic weight_load = 1'b0, weight_swap = 1'b0;
   logic [A-1:0] activation = '0, activation_out;
   logic [P-1:0] partial_sum_in = '0, golden_sig = '0, partial_sum_out;
   logic is_signed = 1'b0, scan_en = 1'b0, pe_disable_in = 1'b0, test_start = 1'b0;
   logic pe_disable_out, test_busy, test_done, test_fail;
   int checks = 0, failures = 0;
   logic [P-1:0] exp_q[$];
   logic [W-1:0] m_shadow = '0, m_active = '0;
   logic [A-1:0] m_act = '0;
   logic m_fault = 1'b0;
   logic [P-1:0] g_u, g_s;
   strait_pe_selftest dut (
      .clk(clk), .rst(rst), .weight_in(weight_in), .weight_load(weight_load),
      .weight_swap(weight_swap), .activation(activation), .partial_sum_in(partial_sum_in),
      .is_signed(is_signed), .scan_en(scan_en), .pe_disable_in(pe_disable_in),
      .test_start(test_start), .golden_sig(golden_sig), .weight_out(weight_out),
      .activation_out(activation_out), .partial_sum_out(partial_sum_out),
      .pe_disable_out(pe_disable_out), .test_busy(test_busy), .test_done(test_done),
      .test_fail(test_fail)
   );
   always #5 clk = ~clk;
   function automatic logic [P-1:0] mac_model(input logic [W-1:0] w, input logic [A-1:0] a,
                                              input logic [P-1:0] ps, input logic sg);
      longint wv, av;
      wv = longint'(w);
      av = longint'(a);
      if (sg && w[W-1]) wv = wv - (longint'(1) << W);
      if (sg && a[A-1]) av = av - (longint'(1) << A);
      return P'(wv * av + longint'(ps));
   endfunction
   function automatic logic [P-1:0] golden(input logic sg);
      logic [31:0] l;
      logic [P-1:0] m;
      l = SEED;
      m = '0;
      for (int i = 0; i < TC; i++) begin
         m = {m[P-2:0], m[P-1]} ^ mac_model(l[W-1:0], l[31:32-A], '0, sg);
         l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
      end
      return m;
   endfunction
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic cyc(input logic ld, input logic sw, input logic [W-1:0] w, input logic [A-1:0] a,
                      input logic [P-1:0] ps, input logic sg, input logic sc, input logic dis);
      weight_load = ld; weight_swap = sw; weight_in = w; activation = a;
      partial_sum_in = ps; is_signed = sg; scan_en = sc; pe_disable_in = dis;
      exp_q.push_back((sc | dis | m_fault) ? ps : mac_model(m_active, m_act, ps, sg));
      tick();
      if (sw) m_active = m_shadow;
      if (ld) m_shadow = w;
      m_act = a;
      check("psum_out", 32'(partial_sum_out), 32'(exp_q.pop_front()));
      check("weight_out", 32'(weight_out), 32'(m_shadow));
      check("activation_out", 32'(activation_out), 32'(m_act));
      check("pe_disable_out", 32'(pe_disable_out), 32'(dis | m_fault));
      weight_load = 1'b0; weight_swap = 1'b0; scan_en = 1'b0; pe_disable_in = 1'b0;
   endtask
   task automatic run_test(input logic [P-1:0] g, input logic sg, input logic exp_fail, input logic poke);
      int busy_n, done_n, done_at;
      busy_n = 0; done_n = 0; done_at = 0;
      golden_sig = g; is_signed = sg; test_start = 1'b1;
      tick();
      test_start = 1'b0;
      for (int i = 1; i <= TC + 5; i++) begin
         if (!test_busy) break;
         busy_n++;
         if (test_done) begin done_n++; done_at = i; end
         test_start = poke && i == 10;
         tick();
      end
      test_start = 1'b0;
      check("busy_cycles", 32'(busy_n), 32'(TC + 1));
      check("done_cycle", 32'(done_at), 32'(TC + 1));
      check("done_pulses", 32'(done_n), 32'd1);
      check("test_fail", 32'(test_fail), 32'(exp_fail));
      m_fault = exp_fail;
      cyc(1'b0, 1'b0, '0, m_act, 19'h12345, sg, 1'b0, 1'b0);
   endtask
   initial begin
      g_u = golden(1'b0);
      g_s = golden(1'b1);
      tick();
      tick();
      rst = 1'b0;
      check("rst_psum", 32'(partial_sum_out), 32'd0);
      check("rst_weight", 32'(weight_out), 32'd0);
      check("rst_busy", 32'(test_busy), 32'd0);
      check("rst_fail", 32'(test_fail), 32'd0);
      check("rst_dis", 32'(pe_disable_out), 32'd0);
      // unsigned MAC
      cyc(1'b1, 1'b0, 8'd3, 8'd0, 19'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'd0, 8'd5, 19'd10, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'd0, 8'd5, 19'd10, 1'b0, 1'b0, 1'b0);
      check("mac_25", 32'(partial_sum_out), 32'd25);
      // signed and unsigned interpretation of 0xFF * 2
      cyc(1'b1, 1'b0, 8'hFF, 8'h02, 19'd0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'd0, 8'h02, 19'd0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'd0, 8'h02, 19'd0, 1'b1, 1'b0, 1'b0);
      check("signed_wrap", 32'(partial_sum_out), 32'h7FFFE);
      cyc(1'b0, 1'b0, 8'd0, 8'h02, 19'd0, 1'b0, 1'b0, 1'b0);
      check("unsigned_1fe", 32'(partial_sum_out), 32'h001FE);
      // double buffering
      cyc(1'b1, 1'b0, 8'd3, 8'd1, 19'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'd0, 8'd1, 19'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'd7, 8'd1, 19'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'd0, 8'd1, 19'd0, 1'b0, 1'b0, 1'b0);
      check("db_old_active", 32'(partial_sum_out), 32'd3);
      cyc(1'b0, 1'b1, 8'd0, 8'd1, 19'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'd0, 8'd1, 19'd0, 1'b0, 1'b0, 1'b0);
      check("db_swapped", 32'(partial_sum_out), 32'd7);
      cyc(1'b1, 1'b1, 8'd9, 8'd1, 19'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'd0, 8'd1, 19'd0, 1'b0, 1'b0, 1'b0);
      check("db_load_swap", 32'(partial_sum_out), 32'd7);
      // bypass paths
      cyc(1'b0, 1'b0, 8'd0, 8'd4, 19'h12345, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 8'd0, 8'd4, 19'h12345, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 8'd0, 8'd4, 19'h12345, 1'b0, 1'b0, 1'b0);
      // self-test: pass, mismatch, recovery with ignored restart
      run_test(g_u, 1'b0, 1'b0, 1'b0);
      run_test(g_u ^ 19'd1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 8'd0, m_act, 19'h00abc, 1'b0, 1'b0, 1'b0);
      run_test(g_s, 1'b1, 1'b0, 1'b1);
      // abort by reset in the middle of RUN
      golden_sig = g_u; is_signed = 1'b0; test_start = 1'b1;
      tick();
      test_start = 1'b0;
      repeat (10) tick();
      check("abort_busy_before", 32'(test_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_shadow = '0; m_active = '0; m_act = '0; m_fault = 1'b0;
      check("abort_busy", 32'(test_busy), 32'd0);
      check("abort_done", 32'(test_done), 32'd0);
      check("abort_fail", 32'(test_fail), 32'd0);
      check("abort_psum", 32'(partial_sum_out), 32'd0);
      check("abort_weight", 32'(weight_out), 32'd0);
      check("abort_act", 32'(activation_out), 32'd0);
      activation = '0;
      cyc(1'b0, 1'b0, 8'd0, 8'd0, 19'd5, 1'b0, 1'b0, 1'b0);
      run_test(g_u, 1'b0, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
